// File: rtl/serdes_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serdes_ctrl_pkg
// Description : Shared state encodings and counter widths for the CC_SERDES
//               lane bring-up / supervision sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package serdes_ctrl_pkg;

    localparam int STATE_W   = 3;
    localparam int TIMER_W   = 20;
    localparam int ERR_CNT_W = 16;

    localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] ST_PLL_RST   = 3'd1;
    localparam logic [STATE_W-1:0] ST_TRX_RST   = 3'd2;
    localparam logic [STATE_W-1:0] ST_WAIT_DONE = 3'd3;
    localparam logic [STATE_W-1:0] ST_ALIGN     = 3'd4;
    localparam logic [STATE_W-1:0] ST_LINK_UP   = 3'd5;
    localparam logic [STATE_W-1:0] ST_FAIL      = 3'd6;

endpackage : serdes_ctrl_pkg
`default_nettype wire

// File: rtl/serdes_sync2.sv
`default_nettype none
// ============================================================================
// Module      : serdes_sync2
// Description : Two-flop synchronizer for one asynchronous SerDes status bit.
// Revision    : 1.0 - initial release
// ============================================================================
module serdes_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture; the first stage may go metastable, the second settles it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : serdes_sync2
`default_nettype wire

// File: rtl/serdes_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serdes_link_ctrl
// Description : Bring-up and supervision sequencer for one CC_SERDES lane:
//               PLL/TRX reset sequencing, comma alignment, link-up detection,
//               bounded TRX retries and saturating PRBS error counting.
// Revision    : 1.0 - initial release
// ============================================================================
module serdes_link_ctrl
    import serdes_ctrl_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES = 256,
    parameter int unsigned TRX_RST_CYCLES = 64,
    parameter int unsigned DONE_TIMEOUT   = 65535,
    parameter int unsigned ALIGN_TIMEOUT  = 65535,
    parameter int unsigned ALIGN_STABLE   = 16,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic                 ref_clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 tx_reset_done_i,
    input  logic                 rx_reset_done_i,
    input  logic                 rx_aligned_i,
    input  logic                 tx_buf_err_i,
    input  logic                 rx_buf_err_i,
    input  logic                 rx_prbs_err_i,
    output logic                 pll_rst_o,
    output logic                 trx_rst_o,
    output logic                 comma_det_en_o,
    output logic                 prbs_cnt_rst_o,
    output logic                 link_up_o,
    output logic                 fail_o,
    output logic [STATE_W-1:0]   state_o,
    output logic [3:0]           retry_cnt_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    localparam int c_N_SYNC   = 6;
    localparam int c_IX_TXD   = 0;
    localparam int c_IX_RXD   = 1;
    localparam int c_IX_ALN   = 2;
    localparam int c_IX_TXBUF = 3;
    localparam int c_IX_RXBUF = 4;
    localparam int c_IX_PRBS  = 5;

    localparam logic [TIMER_W-1:0]   c_PLL_LAST    = TIMER_W'(PLL_RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0]   c_TRX_LAST    = TIMER_W'(TRX_RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0]   c_DONE_TO     = TIMER_W'(DONE_TIMEOUT);
    localparam logic [TIMER_W-1:0]   c_ALIGN_TO    = TIMER_W'(ALIGN_TIMEOUT);
    localparam logic [7:0]           c_STABLE_LAST = 8'(ALIGN_STABLE - 1);
    localparam logic [3:0]           c_MAX_RETRY   = 4'(MAX_RETRY);
    localparam logic [ERR_CNT_W-1:0] c_ERR_MAX     = {ERR_CNT_W{1'b1}};

    logic [c_N_SYNC-1:0]  w_async_in;
    logic [c_N_SYNC-1:0]  w_sync;

    logic [STATE_W-1:0]   r_state;
    logic [STATE_W-1:0]   w_next;
    logic [TIMER_W-1:0]   r_timer;
    logic [TIMER_W-1:0]   w_timer_next;
    logic [7:0]           r_stable;
    logic [7:0]           w_stable_next;
    logic [3:0]           r_retry;
    logic [3:0]           w_retry_next;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic [ERR_CNT_W-1:0] w_err_cnt_next;
    logic                 w_retry_path;

    logic r_pll_rst;
    logic r_trx_rst;
    logic r_comma_en;
    logic r_prbs_rst;
    logic r_link_up;
    logic r_fail;

    assign w_async_in = {rx_prbs_err_i, rx_buf_err_i, tx_buf_err_i,
                         rx_aligned_i, rx_reset_done_i, tx_reset_done_i};

    for (genvar gi = 0; gi < c_N_SYNC; gi++) begin : g_sync
        serdes_sync2 u_sync (
            .clk (ref_clk),
            .rst (rst),
            .i_d (w_async_in[gi]),
            .o_q (w_sync[gi])
        );
    end

    // Next-state, retry accounting, timer/stability/error counter updates.
    always_comb begin
        w_next         = r_state;
        w_retry_next   = r_retry;
        w_retry_path   = 1'b0;
        w_stable_next  = 8'd0;
        w_timer_next   = '0;
        w_err_cnt_next = r_err_cnt;

        case (r_state)
            ST_IDLE: begin
                if (start_i) w_next = ST_PLL_RST;
            end
            ST_PLL_RST: begin
                if (r_timer == c_PLL_LAST) w_next = ST_TRX_RST;
            end
            ST_TRX_RST: begin
                if (r_timer == c_TRX_LAST) w_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // Done wins over a coincident timeout.
                if (w_sync[c_IX_TXD] && w_sync[c_IX_RXD]) w_next = ST_ALIGN;
                else if (r_timer == c_DONE_TO)            w_retry_path = 1'b1;
            end
            ST_ALIGN: begin
                // Reaching the stability count wins over a coincident timeout.
                if (w_sync[c_IX_ALN] && (r_stable == c_STABLE_LAST)) w_next = ST_LINK_UP;
                else if (r_timer == c_ALIGN_TO)                       w_retry_path = 1'b1;
            end
            ST_LINK_UP: begin
                if (w_sync[c_IX_TXBUF] || w_sync[c_IX_RXBUF] || !w_sync[c_IX_ALN])
                    w_retry_path = 1'b1;
            end
            ST_FAIL: begin
                w_next = ST_FAIL;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase

        // Retries restart from the TRX reset; the PLL stays locked.
        if (w_retry_path) begin
            if (r_retry == c_MAX_RETRY) begin
                w_next = ST_FAIL;
            end else begin
                w_retry_next = r_retry + 4'd1;
                w_next       = ST_TRX_RST;
            end
        end

        // Dropping start overrides every other transition.
        if (!start_i) w_next = ST_IDLE;

        if (w_next == ST_IDLE) w_retry_next = 4'd0;

        // Timer reloads on every state entry and runs only in timed states.
        if ((w_next == r_state) &&
            ((r_state == ST_PLL_RST) || (r_state == ST_TRX_RST) ||
             (r_state == ST_WAIT_DONE) || (r_state == ST_ALIGN)))
            w_timer_next = r_timer + TIMER_W'(1);

        if ((r_state == ST_ALIGN) && (w_next == ST_ALIGN) && w_sync[c_IX_ALN])
            w_stable_next = r_stable + 8'd1;

        if ((w_next == ST_LINK_UP) && (r_state != ST_LINK_UP))
            w_err_cnt_next = '0;
        else if ((r_state == ST_LINK_UP) && w_sync[c_IX_PRBS] && (r_err_cnt != c_ERR_MAX))
            w_err_cnt_next = r_err_cnt + ERR_CNT_W'(1);
    end

    // State and counter registers.
    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_stable  <= 8'd0;
            r_retry   <= 4'd0;
            r_err_cnt <= '0;
        end else begin
            r_state   <= w_next;
            r_timer   <= w_timer_next;
            r_stable  <= w_stable_next;
            r_retry   <= w_retry_next;
            r_err_cnt <= w_err_cnt_next;
        end
    end

    // Output registers decoded from the next state so they align with state_o.
    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            r_pll_rst  <= 1'b1;
            r_trx_rst  <= 1'b1;
            r_comma_en <= 1'b0;
            r_prbs_rst <= 1'b0;
            r_link_up  <= 1'b0;
            r_fail     <= 1'b0;
        end else begin
            r_pll_rst  <= (w_next == ST_IDLE) || (w_next == ST_PLL_RST);
            r_trx_rst  <= (w_next == ST_IDLE) || (w_next == ST_PLL_RST) ||
                          (w_next == ST_TRX_RST) || (w_next == ST_FAIL);
            r_comma_en <= (w_next == ST_ALIGN) || (w_next == ST_LINK_UP);
            r_prbs_rst <= (w_next == ST_LINK_UP) && (r_state != ST_LINK_UP);
            r_link_up  <= (w_next == ST_LINK_UP);
            r_fail     <= (w_next == ST_FAIL);
        end
    end

    assign pll_rst_o      = r_pll_rst;
    assign trx_rst_o      = r_trx_rst;
    assign comma_det_en_o = r_comma_en;
    assign prbs_cnt_rst_o = r_prbs_rst;
    assign link_up_o      = r_link_up;
    assign fail_o         = r_fail;
    assign state_o        = r_state;
    assign retry_cnt_o    = r_retry;
    assign err_cnt_o      = r_err_cnt;

endmodule : serdes_link_ctrl
`default_nettype wire

// File: tb/tb_serdes_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serdes_link_ctrl
// Description : Directed scoreboard bench for serdes_link_ctrl. Stimulus pushes
//               the expected output snapshot and the cycle it must appear on;
//               a monitor pops one entry per observed output change.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serdes_link_ctrl;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PLL  = 3'd1;
    localparam logic [2:0] S_TRX  = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_ALN  = 3'd4;
    localparam logic [2:0] S_LINK = 3'd5;
    localparam logic [2:0] S_FAIL = 3'd6;

    logic        ref_clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        tx_reset_done_i;
    logic        rx_reset_done_i;
    logic        rx_aligned_i;
    logic        tx_buf_err_i;
    logic        rx_buf_err_i;
    logic        rx_prbs_err_i;
    logic        pll_rst_o;
    logic        trx_rst_o;
    logic        comma_det_en_o;
    logic        prbs_cnt_rst_o;
    logic        link_up_o;
    logic        fail_o;
    logic [2:0]  state_o;
    logic [3:0]  retry_cnt_o;
    logic [15:0] err_cnt_o;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        int          at;
        logic [2:0]  st;
        logic [3:0]  rty;
        logic [15:0] err;
        logic        prst;
    } ev_t;

    ev_t q[$];

    serdes_link_ctrl #(
        .PLL_RST_CYCLES (8),
        .TRX_RST_CYCLES (4),
        .DONE_TIMEOUT   (20),
        .ALIGN_TIMEOUT  (40),
        .ALIGN_STABLE   (4),
        .MAX_RETRY      (2)
    ) dut (
        .ref_clk         (ref_clk),
        .rst             (rst),
        .start_i         (start_i),
        .tx_reset_done_i (tx_reset_done_i),
        .rx_reset_done_i (rx_reset_done_i),
        .rx_aligned_i    (rx_aligned_i),
        .tx_buf_err_i    (tx_buf_err_i),
        .rx_buf_err_i    (rx_buf_err_i),
        .rx_prbs_err_i   (rx_prbs_err_i),
        .pll_rst_o       (pll_rst_o),
        .trx_rst_o       (trx_rst_o),
        .comma_det_en_o  (comma_det_en_o),
        .prbs_cnt_rst_o  (prbs_cnt_rst_o),
        .link_up_o       (link_up_o),
        .fail_o          (fail_o),
        .state_o         (state_o),
        .retry_cnt_o     (retry_cnt_o),
        .err_cnt_o       (err_cnt_o)
    );

    always #5 ref_clk = ~ref_clk;

    // Posedge counter used to timestamp observed output changes.
    always @(posedge ref_clk) cyc <= cyc + 1;

    // Expected snapshot: per-state output levels plus the pushed fields.
    function automatic logic [28:0] exp_vec(input ev_t e);
        logic pll, trx, cde, lu, fl;
        pll = (e.st == S_IDLE) || (e.st == S_PLL);
        trx = (e.st == S_IDLE) || (e.st == S_PLL) || (e.st == S_TRX) || (e.st == S_FAIL);
        cde = (e.st == S_ALN) || (e.st == S_LINK);
        lu  = (e.st == S_LINK);
        fl  = (e.st == S_FAIL);
        return {e.st, pll, trx, cde, e.prst, lu, fl, e.rty, e.err};
    endfunction

    task automatic push(input int at, input logic [2:0] st, input logic [3:0] rty,
                        input logic [15:0] err, input logic prst);
        ev_t e;
        e.at = at; e.st = st; e.rty = rty; e.err = err; e.prst = prst;
        q.push_back(e);
    endtask

    task automatic go_to(input int c);
        while (cyc < c) @(negedge ref_clk);
    endtask

    // Monitor: every change of the output snapshot consumes one expectation.
    initial begin : monitor
        logic [28:0] cur;
        logic [28:0] prev;
        logic [28:0] want;
        bit          first;
        ev_t         e;
        first = 1'b1;
        prev  = '0;
        forever begin
            @(negedge ref_clk);
            cur = {state_o, pll_rst_o, trx_rst_o, comma_det_en_o, prbs_cnt_rst_o,
                   link_up_o, fail_o, retry_cnt_o, err_cnt_o};
            if (first || (cur != prev)) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change cyc=%0d got st=%0d outs=%b rty=%0d err=%h, required no change",
                             cyc, cur[28:26], cur[25:20], cur[19:16], cur[15:0]);
                end else begin
                    e    = q.pop_front();
                    want = exp_vec(e);
                    if ((cur !== want) || ((e.at >= 0) && (e.at != cyc))) begin
                        bad++;
                        $display("FAIL event cyc=%0d got st=%0d pll/trx/cde/prst/lu/fl=%b rty=%0d err=%h | required cyc=%0d st=%0d pll/trx/cde/prst/lu/fl=%b rty=%0d err=%h",
                                 cyc, cur[28:26], cur[25:20], cur[19:16], cur[15:0],
                                 e.at, want[28:26], want[25:20], want[19:16], want[15:0]);
                    end
                end
            end
            prev  = cur;
            first = 1'b0;
        end
    end

    initial begin : stimulus
        int k, p, s, b, a, d, e, f, g;
        logic [7:0] seq;
        rst = 1'b1; start_i = 1'b0;
        tx_reset_done_i = 1'b0; rx_reset_done_i = 1'b0; rx_aligned_i = 1'b0;
        tx_buf_err_i = 1'b0; rx_buf_err_i = 1'b0; rx_prbs_err_i = 1'b0;
        push(-1, S_IDLE, 4'd0, 16'h0000, 1'b0);
        go_to(3);
        rst = 1'b0;

        // Nominal bring-up.
        k = 5;
        go_to(k); start_i = 1'b1;
        push(k + 1,  S_PLL,  4'd0, 16'h0000, 1'b0);
        push(k + 9,  S_TRX,  4'd0, 16'h0000, 1'b0);
        push(k + 13, S_WAIT, 4'd0, 16'h0000, 1'b0);
        go_to(k + 23); tx_reset_done_i = 1'b1; rx_reset_done_i = 1'b1;
        push(k + 26, S_ALN,  4'd0, 16'h0000, 1'b0);
        go_to(k + 31); rx_aligned_i = 1'b1;
        push(k + 37, S_LINK, 4'd0, 16'h0000, 1'b1);
        push(k + 38, S_LINK, 4'd0, 16'h0000, 1'b0);

        // 100 cycles of PRBS errors in LINK_UP.
        p = k + 45;
        go_to(p); rx_prbs_err_i = 1'b1;
        for (int i = 1; i <= 100; i++) push(p + 2 + i, S_LINK, 4'd0, 16'(i), 1'b0);
        go_to(p + 100); rx_prbs_err_i = 1'b0;

        // Counter preset near the top, then saturation.
        s = p + 110;
        go_to(s); rx_prbs_err_i = 1'b1;
        push(s + 1, S_LINK, 4'd0, 16'hFFFA, 1'b0);
        for (int i = 0; i < 5; i++) push(s + 3 + i, S_LINK, 4'd0, 16'hFFFB + 16'(i), 1'b0);
        #2 force dut.r_err_cnt = 16'hFFFA;
        @(negedge ref_clk);
        #2 release dut.r_err_cnt;
        go_to(s + 20); rx_prbs_err_i = 1'b0;

        // Buffer error in LINK_UP: retry, err_cnt held until re-entry.
        b = s + 30;
        go_to(b); rx_buf_err_i = 1'b1;
        push(b + 3,  S_TRX,  4'd1, 16'hFFFF, 1'b0);
        push(b + 7,  S_WAIT, 4'd1, 16'hFFFF, 1'b0);
        push(b + 8,  S_ALN,  4'd1, 16'hFFFF, 1'b0);
        push(b + 12, S_LINK, 4'd1, 16'h0000, 1'b1);
        push(b + 13, S_LINK, 4'd1, 16'h0000, 1'b0);
        go_to(b + 3); rx_buf_err_i = 1'b0;

        // Alignment loss, then a broken alignment run in ALIGN.
        a = b + 20;
        go_to(a); rx_aligned_i = 1'b0;
        push(a + 3,  S_TRX,  4'd2, 16'h0000, 1'b0);
        push(a + 7,  S_WAIT, 4'd2, 16'h0000, 1'b0);
        push(a + 8,  S_ALN,  4'd2, 16'h0000, 1'b0);
        push(a + 20, S_LINK, 4'd2, 16'h0000, 1'b1);
        push(a + 21, S_LINK, 4'd2, 16'h0000, 1'b0);
        seq = 8'b1111_0111;
        for (int i = 0; i < 8; i++) begin
            go_to(a + 10 + i);
            rx_aligned_i = seq[i];
        end

        // Drop start: back to IDLE one cycle later.
        d = a + 30;
        go_to(d); start_i = 1'b0; tx_reset_done_i = 1'b0; rx_reset_done_i = 1'b0;
        push(d + 1, S_IDLE, 4'd0, 16'h0000, 1'b0);

        // Done never arrives: two retries then FAIL.
        e = d + 5;
        go_to(e); start_i = 1'b1;
        push(e + 1,  S_PLL,  4'd0, 16'h0000, 1'b0);
        push(e + 9,  S_TRX,  4'd0, 16'h0000, 1'b0);
        push(e + 13, S_WAIT, 4'd0, 16'h0000, 1'b0);
        push(e + 34, S_TRX,  4'd1, 16'h0000, 1'b0);
        push(e + 38, S_WAIT, 4'd1, 16'h0000, 1'b0);
        push(e + 59, S_TRX,  4'd2, 16'h0000, 1'b0);
        push(e + 63, S_WAIT, 4'd2, 16'h0000, 1'b0);
        push(e + 84, S_FAIL, 4'd2, 16'h0000, 1'b0);
        f = e + 90;
        go_to(f); start_i = 1'b0;
        push(f + 1, S_IDLE, 4'd0, 16'h0000, 1'b0);

        // Asynchronous reset in WAIT_DONE, applied between clock edges.
        g = f + 5;
        go_to(g); start_i = 1'b1;
        push(g + 1,  S_PLL,  4'd0, 16'h0000, 1'b0);
        push(g + 9,  S_TRX,  4'd0, 16'h0000, 1'b0);
        push(g + 13, S_WAIT, 4'd0, 16'h0000, 1'b0);
        push(g + 17, S_IDLE, 4'd0, 16'h0000, 1'b0);
        go_to(g + 16);
        @(posedge ref_clk);
        #1 rst = 1'b1;
        go_to(g + 19); start_i = 1'b0;
        go_to(g + 21); rst = 1'b0;

        go_to(g + 40);
        while (q.size() != 0) begin
            ev_t m;
            m = q.pop_front();
            total++;
            bad++;
            $display("FAIL missing_event got none, required cyc=%0d st=%0d rty=%0d err=%h",
                     m.at, m.st, m.rty, m.err);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serdes_link_ctrl
`default_nettype wire

// File: doc/serdes_link_ctrl.md
Name: serdes_link_ctrl

Overview:
Bring-up and supervision sequencer for one CC_SERDES lane. Drives the PLL and TX/RX resets, waits for reset-done, enables comma alignment, and declares link-up once the lane is stably byte-aligned. After link-up it monitors buffer errors, alignment loss and PRBS errors. It retries TRX bring-up a bounded number of times before latching a fail state. It sits between top-level control and the CC_SERDES reset/comma/PRBS pins.

Parameters:
PLL_RST_CYCLES, 256, ref_clk cycles pll_rst_o is held high in PLL_RST (range 1..2^20-1)
TRX_RST_CYCLES, 64, ref_clk cycles trx_rst_o is held high in TRX_RST (range 1..2^20-1)
DONE_TIMEOUT, 65535, max cycles in WAIT_DONE before retry
ALIGN_TIMEOUT, 65535, max cycles in ALIGN before retry
ALIGN_STABLE, 16, consecutive synced rx_aligned_i cycles required for link-up (range 1..255)
MAX_RETRY, 3, retries allowed before FAIL (range 0..15)

Ports:
ref_clk  in  1  block clock, SerDes reference clock domain
rst  in  1  asynchronous, active-high reset
start_i  in  1  level; high = bring up and hold link, low = return to IDLE
tx_reset_done_i  in  1  TX_RESET_DONE_O (async, synced internally)
rx_reset_done_i  in  1  RX_RESET_DONE_O (async, synced)
rx_aligned_i  in  1  RX_BYTE_IS_ALIGNED_O (async, synced)
tx_buf_err_i  in  1  TX_BUF_ERR_O (async, synced)
rx_buf_err_i  in  1  RX_BUF_ERR_O (async, synced)
rx_prbs_err_i  in  1  RX_PRBS_ERR_O (async, synced)
pll_rst_o  out  1  to PLL_RESET_I
trx_rst_o  out  1  to TX_RESET_I and RX_RESET_I
comma_det_en_o  out  1  to RX_COMMA_DETECT_EN_I, RX_MCOMMA_ALIGN_I, RX_PCOMMA_ALIGN_I
prbs_cnt_rst_o  out  1  to RX_PRBS_CNT_RESET_I
link_up_o  out  1  high only in LINK_UP
fail_o  out  1  high only in FAIL
state_o  out  3  current state encoding
retry_cnt_o  out  4  retries used since leaving IDLE
err_cnt_o  out  16  synced PRBS-error cycles seen in LINK_UP, saturating

Behaviour:
- Reset values: pll_rst_o=1, trx_rst_o=1, comma_det_en_o=0, prbs_cnt_rst_o=0, link_up_o=0, fail_o=0, state_o=IDLE, retry_cnt_o=0, err_cnt_o=0. Synchronizer flops reset to 0.
- All six status inputs pass through 2-flop synchronizers. Latency from an input edge to the FSM is 2 ref_clk cycles. All outputs are registered.
- Single 20-bit timer. It reloads to 0 on every state entry and increments each cycle in the timed states.
- State encodings: IDLE=0, PLL_RST=1, TRX_RST=2, WAIT_DONE=3, ALIGN=4, LINK_UP=5, FAIL=6.
- IDLE: pll_rst_o=1, trx_rst_o=1, retry_cnt cleared. When start_i=1, go to PLL_RST.
- PLL_RST: pll_rst_o=1, trx_rst_o=1. At timer==PLL_RST_CYCLES-1, go to TRX_RST.
- TRX_RST: pll_rst_o=0, trx_rst_o=1. At timer==TRX_RST_CYCLES-1, go to WAIT_DONE.
- WAIT_DONE: trx_rst_o=0.
  - When synced tx_done & rx_done, go to ALIGN.
  - Else at timer==DONE_TIMEOUT, take the retry path.
- ALIGN: comma_det_en_o=1. A stable counter increments while synced aligned=1 and clears to 0 when aligned=0.
  - When the counter reaches ALIGN_STABLE, go to LINK_UP.
  - Else at timer==ALIGN_TIMEOUT, take the retry path.
- LINK_UP entry: prbs_cnt_rst_o pulses high for exactly 1 cycle, err_cnt_o clears to 0, comma_det_en_o stays 1.
- LINK_UP operation:
  - err_cnt_o increments once per cycle with synced prbs_err=1 and saturates at 16'hFFFF.
  - Synced tx_buf_err, rx_buf_err, or aligned=0 takes the retry path.
- Retry path: if retry_cnt==MAX_RETRY, go to FAIL. Otherwise retry_cnt++ and go to TRX_RST. The PLL is not re-reset.
- FAIL: pll_rst_o=0, trx_rst_o=1, comma_det_en_o=0. Holds until start_i=0.
- start_i=0 in any state: next state is IDLE and resets reassert on the following edge. This has priority over all other transitions, including a simultaneous timeout or error.
- Simultaneous done and timeout in WAIT_DONE: done wins. Same rule in ALIGN: reaching ALIGN_STABLE wins over timeout.
- err_cnt_o holds its value outside LINK_UP until the next LINK_UP entry.
- Asynchronous rst mid-operation returns everything to the reset values immediately.

Decomposition:
- Shared package/include serdes_ctrl_pkg holds:
  - state encoding localparams;
  - TIMER_W=20;
  - ERR_CNT_W=16.
- One sub-module, serdes_sync2: 2-flop synchronizer with async active-high reset, instantiated six times.

Test Plan:
1. PLL_RST_CYCLES=8, TRX_RST_CYCLES=4, ALIGN_STABLE=4. Raise start_i; both done inputs rise 10 cycles after trx_rst_o falls; aligned rises 5 cycles later. Expect pll_rst_o high 8 cycles, trx_rst_o low 4 cycles after pll_rst_o falls, link_up_o 1 exactly 2+4 cycles after aligned rises, and a single prbs_cnt_rst_o pulse.
2. DONE_TIMEOUT=20, MAX_RETRY=2, done inputs held 0. Expect three trx_rst_o pulses, retry_cnt_o 0→1→2, then fail_o=1 and state_o=6. Drop start_i; expect state_o=0 one cycle later.
3. In LINK_UP, hold rx_prbs_err_i high for 100 cycles. Expect err_cnt_o=100 and link_up_o unchanged. Force the counter near 16'hFFFF; expect saturation at 16'hFFFF.
4. In LINK_UP, pulse rx_buf_err_i for 3 cycles. Expect link_up_o to drop, retry_cnt_o+1, state_o=2 and pll_rst_o staying 0.
5. In ALIGN, toggle aligned 1,1,1,0,1,1,1,1 with ALIGN_STABLE=4. Expect link-up only after the last four ones.
6. Assert rst mid WAIT_DONE. Expect every output at its reset value without a clock edge.
